// File: rtl/bcd_down_count.sv
// Cascadable multi-digit BCD down counter with parallel load, wrap or one-shot mode.
// Latency: one clock from an enabling/loading edge to the new count, Borrow and Done.
// Backpressure: none; Enable is a per-cycle request and Borrow feeds the next stage's Enable.
module bcd_down_count #(
  parameter int DIGITS = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   load_value_i,
  input  logic                  one_shot_i,
  output logic [4*DIGITS-1:0]   count_o,
  output logic                  borrow_o,
  output logic                  zero_o,
  output logic                  done_o
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] count_q, count_d;
  logic         borrow_q, borrow_d;
  logic         done_q, done_d;

  logic [W-1:0] load_clamped;
  logic [W-1:0] count_dec;
  logic         is_zero;
  logic         is_one;
  logic         lower_zero;
  logic [3:0]   dig;

  assign is_zero = (count_q == '0);
  assign is_one  = (count_q == W'(1));

  // Per-digit clamp of the load value and BCD decrement with ripple borrow.
  always_comb begin
    load_clamped = '0;
    count_dec    = '0;
    lower_zero   = 1'b1;
    dig          = 4'd0;
    for (int n = 0; n < DIGITS; n++) begin
      dig = load_value_i[4*n +: 4];
      load_clamped[4*n +: 4] = (dig > 4'd9) ? 4'd9 : dig;
      dig = count_q[4*n +: 4];
      if (lower_zero) begin
        count_dec[4*n +: 4] = (dig == 4'd0) ? 4'd9 : (dig - 4'd1);
      end else begin
        count_dec[4*n +: 4] = dig;
      end
      lower_zero = lower_zero & (dig == 4'd0);
    end
  end

  // Next state: Load beats Enable beats hold; Borrow is a one-cycle wrap pulse.
  always_comb begin
    count_d  = count_q;
    borrow_d = 1'b0;
    done_d   = done_q;
    if (load_i) begin
      count_d = load_clamped;
      done_d  = 1'b0;
    end else if (enable_i) begin
      if (!is_zero) begin
        count_d = count_dec;
        if (is_one && one_shot_i) begin
          done_d = 1'b1;
        end
      end else if (!one_shot_i) begin
        count_d  = {DIGITS{4'h9}};
        borrow_d = 1'b1;
      end else begin
        done_d = 1'b1;
      end
    end
  end

  // State registers, cleared asynchronously by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q  <= '0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
    end
  end

  assign count_o  = count_q;
  assign borrow_o = borrow_q;
  assign zero_o   = is_zero;
  assign done_o   = done_q;

endmodule
